// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write controller.
// Optional macro LCD_INIT_SEQ_EN adds the power-up wait and init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENHI,
    ST_HOLD,
    ST_EXEC
`ifdef LCD_INIT_SEQ_EN
    ,
    ST_PWRUP,
    ST_INIT
`endif
  } lcd_state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // Clear/home instructions need the long execution wait.
  function automatic logic is_long(input logic rs,
                                   input logic [7:0] data);
    return !rs && (data == CMD_CLEAR ||
                   data == CMD_HOME  ||
                   data == CMD_HOME_ALT);
  endfunction

  // A zero-length phase still takes one cycle.
  function automatic int eff_cyc(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

`ifdef LCD_INIT_SEQ_EN
  localparam int INIT_LEN = 5;
  // Entry 0 is the LSB byte: 0x38, 0x38, 0x0C, 0x01, 0x06.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38};
`endif

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO of lcd_cmd_t; wrap-bit pointers give full/empty.
// Ports: clk, rst, push, wdata, pop, rdata (head), full, empty.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  lcd_cmd_t wdata,
  input  logic     pop,
  output lcd_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  lcd_cmd_t     mem [FIFO_DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata   = mem[rp[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_write_ctrl.sv
// Queues LCD write commands and replays them to an HD44780 panel with
// setup / enable / hold / execution timing. Ports: cmd_valid_i,
// cmd_ready_o, cmd_rs_i, cmd_data_i (command in); lcd_on_i/o, lcd_en_o,
// lcd_rs_o, lcd_rw_o, lcd_data_o (panel pins); busy_o.
// Macro LCD_INIT_SEQ_EN: power-up wait plus built-in init sequence.
module lcd_write_ctrl
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int T_SETUP_CYC     = 2,
  parameter int T_EN_CYC        = 12,
  parameter int T_HOLD_CYC      = 2,
  parameter int T_EXEC_CYC      = 2000,
  parameter int T_EXEC_LONG_CYC = 80000,
  parameter int T_PWRUP_CYC     = 750000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  input  logic       lcd_on_i,
  output logic       busy_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

`ifdef LCD_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  localparam int SET_N  = eff_cyc(T_SETUP_CYC);
  localparam int EN_N   = eff_cyc(T_EN_CYC);
  localparam int HOLD_N = eff_cyc(T_HOLD_CYC);
  localparam int EXEC_N = eff_cyc(T_EXEC_CYC);
  localparam int LONG_N = eff_cyc(T_EXEC_LONG_CYC);
  localparam int PWR_N  =
    INIT_EN ? eff_cyc(T_PWRUP_CYC) : 1;

  localparam int MAX_N =
    max_int(max_int(max_int(SET_N, EN_N),
                    max_int(HOLD_N, EXEC_N)),
            max_int(LONG_N, PWR_N));
  localparam int CW = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] SET_LD  = CW'(SET_N - 1);
  localparam logic [CW-1:0] EN_LD   = CW'(EN_N - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_N - 1);
  localparam logic [CW-1:0] EXEC_LD = CW'(EXEC_N - 1);
  localparam logic [CW-1:0] LONG_LD = CW'(LONG_N - 1);
`ifdef LCD_INIT_SEQ_EN
  localparam logic [CW-1:0] PWR_LD  = CW'(PWR_N - 1);
`endif

  lcd_state_t    state;
  logic [CW-1:0] cnt;
  logic          en;
  logic          rs;
  logic [7:0]    data;
  logic          on;

  lcd_cmd_t      wr_cmd;
  lcd_cmd_t      head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ready;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0]    init_idx;
  logic          init_done;
  assign ready = init_done && !full;
`else
  logic          up;
  assign ready = up && !full;
`endif

  assign wr_cmd = '{rs: cmd_rs_i, data: cmd_data_i};
  assign push   = cmd_valid_i && ready;
  assign pop    = (state == ST_IDLE) && !empty;

  lcd_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en    <= 1'b0;
      rs    <= 1'b0;
      data  <= '0;
      on    <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      state     <= ST_PWRUP;
      cnt       <= PWR_LD;
      init_idx  <= '0;
      init_done <= 1'b0;
`else
      state <= ST_IDLE;
      cnt   <= '0;
      up    <= 1'b0;
`endif
    end else begin
      on <= lcd_on_i;
`ifndef LCD_INIT_SEQ_EN
      up <= 1'b1;
`endif
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            rs    <= head.rs;
            data  <= head.data;
            cnt   <= SET_LD;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            en    <= 1'b1;
            cnt   <= EN_LD;
            state <= ST_ENHI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ENHI: begin
          if (cnt == '0) begin
            en    <= 1'b0;
            cnt   <= HOLD_LD;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long(rs, data) ? LONG_LD : EXEC_LD;
            state <= ST_EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
            state <= init_done ? ST_IDLE : ST_INIT;
`else
            state <= ST_IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef LCD_INIT_SEQ_EN
        ST_PWRUP: begin
          if (cnt == '0) state <= ST_INIT;
          else           cnt   <= cnt - 1'b1;
        end
        ST_INIT: begin
          if (init_idx == 3'(INIT_LEN)) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            rs       <= 1'b0;
            data     <= INIT_ROM[init_idx];
            init_idx <= init_idx + 1'b1;
            cnt      <= SET_LD;
            state    <= ST_SETUP;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = ready;
  assign busy_o      = (state != ST_IDLE) || !empty;
  assign lcd_on_o    = on;
  assign lcd_en_o    = en;
  assign lcd_rs_o    = rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Randomized bench for lcd_write_ctrl with a timing/ordering model.
// Shortened timing parameters keep the run small.
module tb_lcd_write_ctrl;

  localparam int DEPTH = 8;
  localparam int TS    = 2;
  localparam int TE    = 12;
  localparam int TH    = 2;
  localparam int TX    = 40;
  localparam int TXL   = 300;
  localparam int TPW   = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       rs_in;
  logic [7:0] data_in;
  logic       on_in;
  logic       ready;
  logic       busy;
  logic       on_out;
  logic       en;
  logic       rs_out;
  logic       rw;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  lcd_write_ctrl #(
    .FIFO_DEPTH      (DEPTH),
    .T_SETUP_CYC     (TS),
    .T_EN_CYC        (TE),
    .T_HOLD_CYC      (TH),
    .T_EXEC_CYC      (TX),
    .T_EXEC_LONG_CYC (TXL),
    .T_PWRUP_CYC     (TPW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (valid),
    .cmd_ready_o (ready),
    .cmd_rs_i    (rs_in),
    .cmd_data_i  (data_in),
    .lcd_on_i    (on_in),
    .busy_o      (busy),
    .lcd_on_o    (on_out),
    .lcd_en_o    (en),
    .lcd_rs_o    (rs_out),
    .lcd_rw_o    (rw),
    .lcd_data_o  (data_out)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each accepted command gets a scheduled
  // EN-rise edge and a completion edge from plain arithmetic.
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fin;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   next_free = 0;
  int   last_end  = 0;
  int   fall_exp  = 0;
  int   acc_cnt   = 0;
  int   stall_at  = -1;
  logic prev_en   = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_on   = 1'b0;

`ifdef LCD_INIT_SEQ_EN
  logic [7:0] rom [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exec_len(input logic r,
                                  input logic [7:0] d);
    return (!r && d >= 8'd1 && d <= 8'd3) ? TXL : TX;
  endfunction

  task automatic sched(input logic r, input logic [7:0] d,
                       input int earliest);
    exp_t e;
    int   p;
    p      = (earliest > next_free) ? earliest : next_free;
    e.rs   = r;
    e.data = d;
    e.rise = p + TS;
    e.fin  = p + TS + TE + TH + exec_len(r, d);
    q.push_back(e);
    next_free = e.fin + 1;
    last_end  = e.fin;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      next_free = 0;
`ifdef LCD_INIT_SEQ_EN
      next_free = cyc + 1 + TPW + 1;
      for (int i = 0; i < 5; i++) sched(1'b0, rom[i], 0);
      last_end = last_end + 1;
`endif
      prev_en   = 1'b0;
      prev_busy = 1'b0;
      prev_on   = 1'b0;
    end else begin
      if (!busy && prev_busy) chk("busy_fall", cyc, last_end);
      chk("on_follow", on_out, prev_on);
      if (en && !prev_en) begin
        if (q.size() == 0) begin
          chk("unexpected_en", 1, 0);
        end else begin
          e = q.pop_front();
          chk("en_rs", rs_out, e.rs);
          chk("en_data", data_out, e.data);
          chk("en_rise", cyc, e.rise);
          fall_exp = e.rise + TE;
        end
      end
      if (!en && prev_en) chk("en_fall", cyc, fall_exp);
      if (valid && ready) begin
        acc_cnt++;
        sched(rs_in, data_in, cyc + 2);
      end
      if (valid && !ready && stall_at < 0) stall_at = acc_cnt;
      prev_en   = en;
      prev_busy = busy;
      prev_on   = on_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic r, input logic [7:0] d);
    bit got;
    got     = 1'b0;
    valid   = 1'b1;
    rs_in   = r;
    data_in = d;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = ready;
      step();
    end
    valid = 1'b0;
    if (!got) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int lim, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    step();
  endtask

  task automatic wait_ready(input int lim, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int at;
    int tgt;
    logic       r;
    logic [7:0] d;

    rst     = 1'b1;
    valid   = 1'b0;
    rs_in   = 1'b0;
    data_in = 8'h00;
    on_in   = 1'b0;
    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_en", en, 0);
    chk("rst_rs", rs_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_on", on_out, 0);
    chk("rst_rw", rw, 0);
    rst = 1'b0;
    step();
`ifdef LCD_INIT_SEQ_EN
    chk("init_ready_low", ready, 0);
    chk("init_busy", busy, 1);
    wait_ready(5000, at);
    chk("init_ready_at", at, last_end);
    chk("init_rom_drained", q.size(), 0);
`else
    chk("ready_after_rst", ready, 1);
`endif

    // Single write
    push_cmd(1'b1, 8'h41);
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("single_data_t1", data_out, 8'h41);
    chk("single_rs_t1", rs_out, 1);
    chk("single_en_t1", en, 0);
    wait_idle(500, at);
    chk("single_done", at - t0, 1 + TS + TE + TH + TX);

    // Long and short variants of 0x01
    push_cmd(1'b0, 8'h01);
    t0 = cyc;
    wait_idle(1000, at);
    chk("long_exec", at - t0, 1 + TS + TE + TH + TXL);
    push_cmd(1'b1, 8'h01);
    t0 = cyc;
    wait_idle(1000, at);
    chk("data01_exec", at - t0, 1 + TS + TE + TH + TX);

    // Full FIFO with valid held
    acc_cnt  = 0;
    stall_at = -1;
    for (int i = 0; i < 10; i++) push_cmd(1'(i), 8'hA0 + 8'(i));
    chk("full_accepts", stall_at, 9);
    wait_idle(2000, at);
    chk("full_drained", q.size(), 0);

    // lcd_on toggles during EXEC
    push_cmd(1'b1, 8'h55);
    t0  = cyc;
    tgt = t0 + 1 + TS + TE + TH + 5;
    while (cyc < tgt) step();
    on_in = 1'b1;
    @(negedge clk);
    chk("on_before", on_out, 0);
    @(negedge clk);
    chk("on_after", on_out, 1);
    step();
    on_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("on_off", on_out, 0);
    wait_idle(500, at);
    chk("on_timing", at - t0, 1 + TS + TE + TH + TX);

    // Reset during the enable pulse
    push_cmd(1'b1, 8'h11);
    push_cmd(1'b1, 8'h22);
    push_cmd(1'b0, 8'h33);
    at = 0;
    for (int i = 0; i < 100 && !en; i++) @(negedge clk);
    chk("en_seen", en, 1);
    step();
    rst = 1'b1;
    step();
    chk("midrst_en", en, 0);
    chk("midrst_rs", rs_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_ready", ready, 0);
    rst = 1'b0;
    repeat (300) step();
`ifndef LCD_INIT_SEQ_EN
    chk("midrst_quiet", busy, 0);
`endif
    wait_ready(5000, at);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 80)) step();
      on_in = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 4));
      else                           d = 8'($urandom);
      push_cmd(r, d);
    end
    wait_idle(20000, at);
    chk("rand_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_write_ctrl.md
Name: lcd_write_ctrl

Overview:
- Downstream of the pipelined core's LCD output register.
- Accepts byte-wide LCD write commands (RS + data) from the core's LCD store path into a small FIFO.
- Replays each command to an HD44780-compatible panel with correct setup, enable-pulse, hold and execution timing, so firmware never busy-waits.
- Drives the physical LCD pins: ON, EN, RS, RW, DATA[7:0].

Parameters:
- FIFO_DEPTH, 8, command queue entries; must be a power of 2, ≥2.
- T_SETUP_CYC, 2, cycles RS/DATA are stable before EN rises.
- T_EN_CYC, 12, cycles EN is held high.
- T_HOLD_CYC, 2, cycles RS/DATA are held after EN falls.
- T_EXEC_CYC, 2000, post-write wait for a normal command or data write (40 us at 50 MHz).
- T_EXEC_LONG_CYC, 80000, post-write wait for clear/home (1.6 ms at 50 MHz).
- T_PWRUP_CYC, 750000, power-up wait before the init sequence; used only with LCD_INIT_SEQ_EN.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  FIFO can accept
- cmd_rs_i  in  1  0 = instruction, 1 = data
- cmd_data_i  in  8  command/data byte
- lcd_on_i  in  1  backlight/power request from the core
- busy_o  out  1  FSM not IDLE, or FIFO non-empty
- lcd_on_o  out  1  registered lcd_on_i
- lcd_en_o  out  1  panel enable strobe
- lcd_rs_o  out  1  panel register select
- lcd_rw_o  out  1  panel read/write; tied 0 (write only)
- lcd_data_o  out  8  panel data bus

Behaviour:
- Clocking and reset: everything is on the rising edge of clk_i; rst_i is synchronous and active-high.
- Reset values: all outputs 0, cmd_ready_o = 0; FIFO flushed; FSM in IDLE (or PWRUP with the optional feature). cmd_ready_o goes 1 the cycle after reset deasserts.
- Reset mid-command: EN drops to 0 at that same edge and the queued commands are discarded.
- Handshake: a push occurs on an edge where cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !full, from registered FIFO state only.
  - A pop in the same cycle does not make room for a push in that cycle.
  - cmd_valid_i while not ready is ignored; the producer must hold it.
- FIFO: head/tail pointers are log2(FIFO_DEPTH)+1 bits and wrap; full and empty are decided by MSB compare. Simultaneous push and pop with the FIFO non-full and non-empty leaves the count unchanged.
- FSM states: IDLE -> SETUP -> ENHI -> HOLD -> EXEC -> IDLE.
  - IDLE: if FIFO non-empty, pop and go to SETUP. lcd_rs_o and lcd_data_o are registered from the popped entry at that edge.
  - SETUP: T_SETUP_CYC cycles, then EN is set to 1.
  - ENHI: T_EN_CYC cycles, then EN is cleared.
  - HOLD: T_HOLD_CYC cycles; RS/DATA are unchanged.
  - EXEC: T_EXEC_LONG_CYC cycles if rs==0 and data ∈ {0x01, 0x02, 0x03}; otherwise T_EXEC_CYC cycles.
- Latency: handshake edge t0 gives RS/DATA valid at t0+1, EN high over [t0+3, t0+15), EXEC from t0+17, IDLE at t0+2017 (defaults).
- Throughput: back-to-back commands start every 1+S+E+H+X cycles.
- Outputs: lcd_rs_o and lcd_data_o change only on the IDLE->SETUP transition and otherwise hold their last value.
- Delay counter: a single down-counter sized $clog2(max timing param + 1). It is loaded on each state entry with the param minus 1, and the state advances when the counter reads 0. Any param of 0 is treated as 1.
- lcd_on_o follows lcd_on_i with a 1-cycle register, independent of the FSM.

Optional Feature:
- LCD_INIT_SEQ_EN: adds states PWRUP and INIT.
  - After reset, the FSM waits T_PWRUP_CYC cycles, then plays a fixed ROM (rs=0): 0x38, 0x38, 0x0C, 0x01, 0x06. Each entry uses the normal SETUP/ENHI/HOLD/EXEC path, with long-exec applied to 0x01.
  - cmd_ready_o stays 0 until the ROM completes; busy_o stays 1.
- Without the macro: reset goes directly to IDLE and firmware performs initialisation.

Decomposition:
- Package lcd_pkg contains:
  - the state enum typedef;
  - the lcd_cmd_t struct (rs, data[7:0]);
  - long-command codes 0x01/0x02/0x03;
  - the init ROM constant array, which lives under LCD_INIT_SEQ_EN.
- Sub-module lcd_cmd_fifo: a generic sync FIFO of lcd_cmd_t with parameter FIFO_DEPTH and ports push/pop/full/empty/rdata.

Test Plan:
- Single write: push rs=1, data=0x41 at t0 -> lcd_data_o=0x41 and lcd_rs_o=1 at t0+1; lcd_en_o high for exactly 12 cycles starting t0+3; busy_o falls at t0+2017.
- Long command: push rs=0, data=0x01 -> EXEC lasts 80000 cycles. Repeat with rs=1, data=0x01 -> EXEC lasts 2000 cycles.
- Full FIFO: push 10 commands back-to-back with valid held -> cmd_ready_o=0 after 9 accepts (8 queued + 1 popped); all bytes appear on lcd_data_o in order, with none lost or duplicated.
- Reset mid-pulse: assert rst_i during ENHI -> lcd_en_o=0 and all outputs 0 at that edge; no queued command is emitted afterwards.
- lcd_on_i toggle during EXEC -> lcd_on_o follows 1 cycle later and the FSM timing is unaffected.
- With LCD_INIT_SEQ_EN: after reset, cmd_ready_o=0 for T_PWRUP_CYC plus the full init sequence; EN pulses carry 0x38, 0x38, 0x0C, 0x01, 0x06 in order; then cmd_ready_o=1.
